// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    CORE = 1'b0,
    EXT  = 1'b1
  } owner_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core M-stage and an external (debug/DMA) port.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution instead of core priority with starvation escape.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic core_gnt;

`ifdef DMEM_ARB_RR_EN
  owner_t last_grant;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
`endif

  assign core_rdata = mem_rdata;

  // Nothing is granted while reset is held low, even though reset is asynchronous.
  always_comb begin
    core_gnt   = 1'b0;
    ext_gnt    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    if (reset) begin
      if (core_req && ext_req) begin
`ifdef DMEM_ARB_RR_EN
        if (last_grant == CORE) ext_gnt = 1'b1;
        else                    core_gnt = 1'b1;
`else
        if (starve_cnt == STARVE_LIM) ext_gnt = 1'b1;
        else                          core_gnt = 1'b1;
`endif
      end else begin
        core_gnt = core_req;
        ext_gnt  = ext_req;
      end
    end
    if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (core_gnt) begin
      mem_we = core_we;
    end
    core_stall = reset & core_req & ~core_gnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= EXT;
`else
      starve_cnt <= '0;
`endif
    end else begin
      ext_rvalid <= ext_gnt & ~ext_we;
      if (ext_gnt && !ext_we) ext_rdata <= mem_rdata;
`ifdef DMEM_ARB_RR_EN
      if (core_gnt)     last_grant <= CORE;
      else if (ext_gnt) last_grant <= EXT;
`else
      // Saturating count of conflicts ext has lost since its last grant.
      if (ext_gnt)                                          starve_cnt <= '0;
      else if (core_req && ext_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter; ext read data is tracked through a scoreboard queue.
module tb_dmem_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              core_stall;
  logic              ext_req, ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt, ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int passes = 0;
  logic [DATA_W-1:0] rdata_q[$];

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    core_req = 1; core_we = 1; ext_req = 1; ext_we = 1;
    mem_rdata = 32'h1111_2222;
    @(negedge clk); #1;
    checks++; if (mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we got %b want 0", mem_we); else passes++;
    checks++; if (ext_gnt !== 1'b0) $display("[TB] FAIL reset_ext_gnt got %b want 0", ext_gnt); else passes++;
    checks++; if (core_stall !== 1'b0) $display("[TB] FAIL reset_core_stall got %b want 0", core_stall); else passes++;
    checks++; if (ext_rvalid !== 1'b0) $display("[TB] FAIL reset_ext_rvalid got %b want 0", ext_rvalid); else passes++;
    checks++; if (ext_rdata !== '0) $display("[TB] FAIL reset_ext_rdata got %h want 0", ext_rdata); else passes++;
    @(negedge clk);
    idle_inputs();
    reset = 1;
  endtask

  task automatic test_core_only();
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 32'h40; mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (core_rdata !== 32'hDEAD_BEEF) $display("[TB] FAIL core_rdata got %h want deadbeef", core_rdata); else passes++;
    checks++; if (core_stall !== 1'b0) $display("[TB] FAIL core_only_stall got %b want 0", core_stall); else passes++;
    checks++; if (mem_we !== 1'b0) $display("[TB] FAIL core_read_mem_we got %b want 0", mem_we); else passes++;
    checks++; if (mem_addr !== 32'h40) $display("[TB] FAIL core_mem_addr got %h want 40", mem_addr); else passes++;
    @(negedge clk);
    core_we = 1; core_addr = 32'h44; core_wdata = 32'h0BAD_F00D;
    #1;
    checks++; if (mem_we !== 1'b1) $display("[TB] FAIL core_write_mem_we got %b want 1", mem_we); else passes++;
    checks++; if (mem_wdata !== 32'h0BAD_F00D) $display("[TB] FAIL core_wdata got %h want 0badf00d", mem_wdata); else passes++;
    checks++; if (ext_gnt !== 1'b0) $display("[TB] FAIL core_only_ext_gnt got %b want 0", ext_gnt); else passes++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_ext_write();
    @(negedge clk);
    ext_req = 1; ext_we = 1; ext_addr = 32'h80; ext_wdata = 32'h1234_5678;
    core_addr = 32'h999;
    #1;
    checks++; if (ext_gnt !== 1'b1) $display("[TB] FAIL ext_wr_gnt got %b want 1", ext_gnt); else passes++;
    checks++; if (mem_we !== 1'b1) $display("[TB] FAIL ext_wr_mem_we got %b want 1", mem_we); else passes++;
    checks++; if (mem_addr !== 32'h80) $display("[TB] FAIL ext_wr_addr got %h want 80", mem_addr); else passes++;
    checks++; if (mem_wdata !== 32'h1234_5678) $display("[TB] FAIL ext_wr_data got %h want 12345678", mem_wdata); else passes++;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ext_rvalid !== 1'b0) $display("[TB] FAIL ext_wr_rvalid got %b want 0", ext_rvalid); else passes++;
    checks++; if (mem_addr !== '0) $display("[TB] FAIL idle_mem_addr got %h want core addr 0", mem_addr); else passes++;
  endtask

  task automatic test_ext_read();
    logic [DATA_W-1:0] exp;
    bit seen;
    @(negedge clk);
    ext_req = 1; ext_we = 0; ext_addr = 32'h84; mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (ext_gnt !== 1'b1) $display("[TB] FAIL ext_rd_gnt got %b want 1", ext_gnt); else passes++;
    if (ext_gnt === 1'b1) rdata_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    idle_inputs();
    mem_rdata = 32'h5555_5555;
    #1;
    checks++; if (ext_rvalid !== 1'b1) $display("[TB] FAIL ext_rd_rvalid_n1 got %b want 1", ext_rvalid); else passes++;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (ext_rvalid === 1'b1) seen = 1;
      else begin @(negedge clk); #1; end
    end
    checks++;
    if (!seen) $display("[TB] FAIL ext_rd_timeout got no rvalid want rvalid within 4 cycles");
    else if (rdata_q.size() == 0) $display("[TB] FAIL ext_rd_unexpected got rvalid want empty scoreboard");
    else begin
      exp = rdata_q.pop_front();
      if (ext_rdata !== exp) $display("[TB] FAIL ext_rd_data got %h want %h", ext_rdata, exp); else passes++;
    end
    @(negedge clk); #1;
    checks++; if (ext_rvalid !== 1'b0) $display("[TB] FAIL ext_rd_rvalid_n2 got %b want 0", ext_rvalid); else passes++;
    checks++; if (ext_rdata !== 32'hCAFE_F00D) $display("[TB] FAIL ext_rdata_hold got %h want cafef00d", ext_rdata); else passes++;
  endtask

  task automatic test_conflict();
    bit pend, exp_ext;
    logic [DATA_W-1:0] exp;
    reset = 0;
    idle_inputs();
    @(negedge clk);
    reset = 1;
    pend = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 10) begin
        core_req = 1; core_we = 0; core_addr = 32'h100 + i;
        ext_req = 1; ext_we = 0; ext_addr = 32'h200 + i;
      end else idle_inputs();
      mem_rdata = 32'hA000_0000 + i;
      #1;
      checks++;
      if (pend) begin
        if (ext_rvalid !== 1'b1) $display("[TB] FAIL conflict_rvalid cyc %0d got %b want 1", i, ext_rvalid);
        else if (rdata_q.size() == 0) $display("[TB] FAIL conflict_sb cyc %0d got rvalid want empty scoreboard", i);
        else begin
          exp = rdata_q.pop_front();
          if (ext_rdata !== exp) $display("[TB] FAIL conflict_rdata cyc %0d got %h want %h", i, ext_rdata, exp);
          else passes++;
        end
      end else begin
        if (ext_rvalid !== 1'b0) $display("[TB] FAIL conflict_rvalid cyc %0d got %b want 0", i, ext_rvalid); else passes++;
      end
      if (i < 10) begin
`ifdef DMEM_ARB_RR_EN
        exp_ext = (i % 2) == 1;
`else
        exp_ext = (i % (STARVE_MAX + 1)) == STARVE_MAX;
`endif
        checks++; if (ext_gnt !== exp_ext) $display("[TB] FAIL conflict_gnt cyc %0d got %b want %b", i, ext_gnt, exp_ext); else passes++;
        checks++; if (core_stall !== exp_ext) $display("[TB] FAIL conflict_stall cyc %0d got %b want %b", i, core_stall, exp_ext); else passes++;
        checks++;
        if (mem_addr !== (exp_ext ? ext_addr : core_addr))
          $display("[TB] FAIL conflict_addr cyc %0d got %h want %h", i, mem_addr, exp_ext ? ext_addr : core_addr);
        else passes++;
        if (exp_ext) rdata_q.push_back(mem_rdata);
        pend = exp_ext;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle_inputs();
    ext_req = 1; ext_we = 0; ext_addr = 32'h84; mem_rdata = 32'h55AA_55AA;
    #1;
    checks++; if (ext_gnt !== 1'b1) $display("[TB] FAIL mid_pre_gnt got %b want 1", ext_gnt); else passes++;
    #1;
    reset = 0;
    ext_we = 1; core_req = 1; core_we = 1;
    #1;
    checks++; if (mem_we !== 1'b0) $display("[TB] FAIL mid_mem_we got %b want 0", mem_we); else passes++;
    checks++; if (ext_gnt !== 1'b0) $display("[TB] FAIL mid_ext_gnt got %b want 0", ext_gnt); else passes++;
    checks++; if (core_stall !== 1'b0) $display("[TB] FAIL mid_core_stall got %b want 0", core_stall); else passes++;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) $display("[TB] FAIL mid_mem_we_hold got %b want 0", mem_we); else passes++;
    reset = 1;
    idle_inputs();
    @(negedge clk); #1;
    checks++; if (ext_rvalid !== 1'b0) $display("[TB] FAIL mid_rvalid got %b want 0", ext_rvalid); else passes++;
    checks++; if (ext_rdata !== '0) $display("[TB] FAIL mid_rdata got %h want 0", ext_rdata); else passes++;
    @(negedge clk); #1;
    checks++; if (ext_rvalid !== 1'b0) $display("[TB] FAIL mid_rvalid_late got %b want 0", ext_rvalid); else passes++;
  endtask

  initial begin
    mem_rdata = '0;
    test_reset();
    test_core_only();
    test_ext_write();
    test_ext_read();
    test_conflict();
    test_reset_mid();
    checks++;
    if (rdata_q.size() != 0) $display("[TB] FAIL scoreboard_drain got %0d entries want 0", rdata_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
